column_frame_loader: RTL and testbench
======================================

COLUMN_FRAME_LOADER -- requirements
Module: column_frame_loader

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 20, number of frame strobes driven per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, width of one configuration word and of one row slice.
REQ-003 SHALL have parameter NumberOfRows, default 16, rows per column; FrameData width = FrameBitsPerRow*NumberOfRows.
REQ-004 SHALL have parameter COLUMN_ID, default 0, column index this loader answers to (0..255).
REQ-005 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port WordData  input  FrameBitsPerRow  configuration word from bitstream source.
REQ-008 SHALL have port WordValid  input  1  WordData valid.
REQ-009 SHALL have port WordReady  output  1  loader accepts WordData this cycle.
REQ-010 SHALL have port FrameData  output  FrameBitsPerRow*NumberOfRows  assembled column frame, feeds tile ConfigMem FrameData.
REQ-011 SHALL have port FrameStrobe  output  MaxFramesPerCol  one-hot, one-cycle write pulse to tile ConfigMem.
REQ-012 SHALL have port Busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have port FrameErr  output  1  sticky: a header addressed this column with frame index >= MaxFramesPerCol.

Function
REQ-014 SHALL transfer a word only on a cycle with WordValid and WordReady both high.
REQ-015 SHALL interpret the first accepted word in IDLE as header: bits [7:0] frame index, bits [15:8] column index; other bits ignored.
REQ-016 SHALL implement states IDLE, LOAD, STROBE; IDLE --header--> LOAD; LOAD --NumberOfRows-th data word--> STROBE; STROBE --1 cycle--> IDLE.
REQ-017 SHALL in LOAD accept exactly NumberOfRows data words, counted by a row counter reset to 0 on header acceptance.
REQ-018 SHALL shift each data word into FrameData from the top: first data word ends in the most-significant slice, last word in bits [FrameBitsPerRow-1:0].
REQ-019 SHALL update FrameData only when header column == COLUMN_ID and frame index < MaxFramesPerCol (header "hit"); on miss SHALL consume and discard the data words, leaving FrameData unchanged.
REQ-020 SHALL in STROBE, on hit, drive FrameStrobe[frame index]=1 for exactly that one cycle, all other bits 0; on miss FrameStrobe SHALL stay 0.
REQ-021 SHALL hold FrameData stable during the STROBE cycle and thereafter until the next hit load begins.
REQ-022 SHALL drive WordReady = 1 in IDLE and LOAD, 0 in STROBE; latency from last data word acceptance to strobe = 1 cycle.
REQ-023 SHALL set FrameErr on header acceptance with column == COLUMN_ID and frame index >= MaxFramesPerCol; only reset clears it.
REQ-024 SHALL tolerate WordValid gaps in LOAD with no state or counter change.
REQ-025 SHALL allow a new header to be accepted in the cycle immediately after STROBE (back-to-back frames, 1 idle-ready cycle overhead).

Reset
REQ-026 SHALL on RST=1 at a clock edge enter IDLE, clear row counter, FrameStrobe=0, FrameData=0, FrameErr=0, Busy=0; WordReady=1 from the next cycle.
REQ-027 SHALL on reset mid-LOAD discard the partial frame and emit no strobe.
REQ-028 SHALL give RST priority over any simultaneous word transfer.

Structure
REQ-029 SHALL place state encoding and header field positions/widths (frame index [7:0], column [15:8]) in shared package fabric_cfg_pkg.
REQ-030 SHALL implement the row shift register as sub-module frame_shift_reg (parameters FrameBitsPerRow, NumberOfRows; shift-enable, data-in, parallel out).

Verification
REQ-031 SHALL cover: COLUMN_ID=0, header 0x0003, 16 words 0x0..0xF -> FrameData slice15=0x0, slice0=0xF; FrameStrobe=0x00008 for one cycle.
REQ-032 SHALL cover: header 0x0105 (column 1) to COLUMN_ID=0 -> 16 words consumed, FrameStrobe stays 0, FrameData unchanged.
REQ-033 SHALL cover: header 0x0014 (frame 20) -> FrameErr=1, no strobe, FrameErr persists until RST.
REQ-034 SHALL cover: RST asserted after 8 data words -> IDLE, FrameData=0, no strobe; following full frame to index 0 -> FrameStrobe=0x00001.
REQ-035 SHALL cover: WordValid toggled randomly during LOAD and two back-to-back frames (indices 2, 19) -> strobes 0x00004 then 0x80000, WordReady=0 only in STROBE cycles.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared configuration-loader definitions: FSM encoding and header field layout.
package fabric_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STROBE = 2'd2
  } loader_state_e;

  // Header word layout: frame index in [7:0], column index in [15:8].
  localparam int unsigned HdrFrameLsb = 0;
  localparam int unsigned HdrFrameW   = 8;
  localparam int unsigned HdrColLsb   = 8;
  localparam int unsigned HdrColW     = 8;

endpackage

// File: rtl/frame_shift_reg.sv
// Row shift register: each enabled word enters the low slice and the
// frame moves up one slice, so the first word ends in the top slice.
module frame_shift_reg #(
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    shift_en,
  input  logic [FrameBitsPerRow-1:0]              data_in,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] frame_out
);

  localparam int FrameW = FrameBitsPerRow * NumberOfRows;

  logic [FrameW-1:0] frame_q;
  logic [FrameW-1:0] frame_d;

  generate
    if (NumberOfRows > 1) begin : g_multi
      // Shift up by one slice when enabled, otherwise hold.
      always_comb begin
        frame_d = frame_q;
        if (shift_en) begin
          frame_d = {frame_q[FrameW-FrameBitsPerRow-1:0], data_in};
        end
      end
    end else begin : g_single
      // Single-row column: the word simply replaces the frame.
      always_comb begin
        frame_d = frame_q;
        if (shift_en) begin
          frame_d = data_in;
        end
      end
    end
  endgenerate

  // Frame storage register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else begin
      frame_q <= frame_d;
    end
  end

  assign frame_out = frame_q;

endmodule

// File: rtl/column_frame_loader.sv
// Column frame loader: takes a header word and NumberOfRows data words,
// assembles the column frame and pulses the addressed frame strobe.
module column_frame_loader
  import fabric_cfg_pkg::*;
#(
  parameter int MaxFramesPerCol = 20,
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int COLUMN_ID       = 0
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [FrameBitsPerRow-1:0]              WordData,
  input  logic                                    WordValid,
  output logic                                    WordReady,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    Busy,
  output logic                                    FrameErr
);

  localparam int RowCntW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowCntW-1:0] LastRow = RowCntW'(NumberOfRows - 1);

  loader_state_e        state_q, state_d;
  logic [RowCntW-1:0]   row_cnt_q, row_cnt_d;
  logic [HdrFrameW-1:0] frame_idx_q, frame_idx_d;
  logic                 hit_q, hit_d;
  logic                 frame_err_q, frame_err_d;

  logic                 accept;
  logic                 shift_en;
  logic [HdrFrameW-1:0] hdr_idx;
  logic [HdrColW-1:0]   hdr_col;
  logic                 col_match;
  logic                 idx_ok;

  assign hdr_idx   = WordData[HdrFrameLsb +: HdrFrameW];
  assign hdr_col   = WordData[HdrColLsb +: HdrColW];
  assign col_match = (hdr_col == HdrColW'(COLUMN_ID));
  assign idx_ok    = (int'(hdr_idx) < MaxFramesPerCol);

  assign WordReady = (state_q != ST_STROBE);
  assign Busy      = (state_q != ST_IDLE);
  assign FrameErr  = frame_err_q;
  assign accept    = WordValid && WordReady;

  // Next-state, header decode and row counting.
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    frame_idx_d = frame_idx_q;
    hit_d       = hit_q;
    frame_err_d = frame_err_q;
    shift_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_idx_d = hdr_idx;
          hit_d       = col_match && idx_ok;
          row_cnt_d   = '0;
          if (col_match && !idx_ok) begin
            frame_err_d = 1'b1;
          end
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Missed headers still consume their data words, just without shifting.
          shift_en = hit_q;
          if (row_cnt_q == LastRow) begin
            row_cnt_d = '0;
            state_d   = ST_STROBE;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      ST_STROBE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset wins over any concurrent transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      frame_idx_q <= '0;
      hit_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      frame_idx_q <= frame_idx_d;
      hit_q       <= hit_d;
      frame_err_q <= frame_err_d;
    end
  end

  // One-hot strobe decode, active only in the STROBE cycle of a hit.
  always_comb begin
    FrameStrobe = '0;
    if ((state_q == ST_STROBE) && hit_q) begin
      for (int unsigned i = 0; i < MaxFramesPerCol; i++) begin
        FrameStrobe[i] = (frame_idx_q == HdrFrameW'(i));
      end
    end
  end

  frame_shift_reg #(
    .FrameBitsPerRow(FrameBitsPerRow),
    .NumberOfRows   (NumberOfRows)
  ) u_shift (
    .clk      (CLK),
    .rst      (RST),
    .shift_en (shift_en),
    .data_in  (WordData),
    .frame_out(FrameData)
  );

endmodule

// File: tb/tb_column_frame_loader.sv
// Directed bench for column_frame_loader with default parameters, COLUMN_ID=0.
module tb_column_frame_loader;

  localparam int FB = 32;
  localparam int NR = 16;
  localparam int MF = 20;
  localparam int FW = FB * NR;

  logic          CLK = 1'b0;
  logic          RST;
  logic [FB-1:0] WordData;
  logic          WordValid;
  logic          WordReady;
  logic [FW-1:0] FrameData;
  logic [MF-1:0] FrameStrobe;
  logic          Busy;
  logic          FrameErr;

  int total = 0;
  int bad   = 0;
  logic [FW-1:0] exp_frame;

  column_frame_loader #(
    .MaxFramesPerCol(MF),
    .FrameBitsPerRow(FB),
    .NumberOfRows   (NR),
    .COLUMN_ID      (0)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WordData   (WordData),
    .WordValid  (WordValid),
    .WordReady  (WordReady),
    .FrameData  (FrameData),
    .FrameStrobe(FrameStrobe),
    .Busy       (Busy),
    .FrameErr   (FrameErr)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Optional idle gap, then one word held until accepted at a rising edge.
  task automatic put_word(input logic [FB-1:0] w, input int unsigned gap);
    int unsigned n;
    for (int unsigned g = 0; g < gap; g++) begin
      WordValid = 1'b0;
      @(posedge CLK); #1;
    end
    n = 0;
    while (!WordReady && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!WordReady) chk("ready_timeout", {{(FW-1){1'b0}}, WordReady}, 1);
    WordData  = w;
    WordValid = 1'b1;
    @(posedge CLK); #1;
    WordValid = 1'b0;
  endtask

  // Header plus NR words base+i; ends 1ns after the last word's edge.
  task automatic send_frame(input logic [FB-1:0] hdr, input logic [FB-1:0] base,
                            input bit upd, input bit rnd);
    logic [FB-1:0] w;
    put_word(hdr, 0);
    for (int unsigned i = 0; i < NR; i++) begin
      w = base + FB'(i);
      put_word(w, rnd ? $urandom_range(0, 3) : 0);
      if (upd) exp_frame = {exp_frame[FW-FB-1:0], w};
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
  endtask

  initial begin
    RST       = 1'b0;
    WordValid = 1'b0;
    WordData  = '0;
    exp_frame = '0;
    do_reset();

    // Reset state
    chk("rst_data",   FrameData,   '0);
    chk("rst_strobe", FW'(FrameStrobe), '0);
    chk("rst_busy",   FW'(Busy),   0);
    chk("rst_err",    FW'(FrameErr), 0);
    chk("rst_ready",  FW'(WordReady), 1);

    // Hit: frame 3, words 0..F
    send_frame(32'h0000_0003, 32'h0, 1'b1, 1'b0);
    chk("f3_strobe", FW'(FrameStrobe), FW'(20'h00008));
    chk("f3_ready",  FW'(WordReady), 0);
    chk("f3_busy",   FW'(Busy), 1);
    chk("f3_top",    FW'(FrameData[FW-1 -: FB]), 0);
    chk("f3_mid7",   FW'(FrameData[7*FB +: FB]), 32'h8);
    chk("f3_low",    FW'(FrameData[FB-1:0]), 32'hF);
    chk("f3_data",   FrameData, exp_frame);
    @(posedge CLK); #1;
    chk("f3_strobe_off", FW'(FrameStrobe), '0);
    chk("f3_idle",   FW'(Busy), 0);
    chk("f3_hold",   FrameData, exp_frame);

    // Miss: column 1
    send_frame(32'h0000_0105, 32'hA5A5_0000, 1'b0, 1'b0);
    chk("miss_ready",  FW'(WordReady), 0);
    chk("miss_strobe", FW'(FrameStrobe), '0);
    chk("miss_data",   FrameData, exp_frame);
    chk("miss_err",    FW'(FrameErr), 0);
    @(posedge CLK); #1;

    // Out-of-range frame 20
    send_frame(32'h0000_0014, 32'h5A5A_0000, 1'b0, 1'b0);
    chk("oor_ready",  FW'(WordReady), 0);
    chk("oor_strobe", FW'(FrameStrobe), '0);
    chk("oor_err",    FW'(FrameErr), 1);
    chk("oor_data",   FrameData, exp_frame);
    @(posedge CLK); #1;

    // Hit after error: error stays sticky, upper header bits ignored
    send_frame(32'hDEAD_000A, 32'h1000_0000, 1'b1, 1'b0);
    chk("f10_strobe", FW'(FrameStrobe), FW'(20'h00400));
    chk("f10_data",   FrameData, exp_frame);
    chk("f10_err",    FW'(FrameErr), 1);
    @(posedge CLK); #1;

    // Reset after header + 8 data words
    put_word(32'h0000_0004, 0);
    for (int unsigned i = 0; i < 8; i++) put_word(32'hC0DE_0000 + 32'(i), 0);
    chk("mid_busy", FW'(Busy), 1);
    do_reset();
    exp_frame = '0;
    chk("mid_rst_data", FrameData, '0);
    chk("mid_rst_busy", FW'(Busy), 0);
    chk("mid_rst_err",  FW'(FrameErr), 0);
    chk("mid_rst_strobe", FW'(FrameStrobe), '0);
    @(posedge CLK); #1;
    chk("mid_rst_strobe2", FW'(FrameStrobe), '0);
    chk("mid_rst_ready", FW'(WordReady), 1);

    // Full frame to index 0 after the aborted one
    send_frame(32'h0000_0000, 32'h0BAD_F000, 1'b1, 1'b0);
    chk("f0_strobe", FW'(FrameStrobe), FW'(20'h00001));
    chk("f0_low",    FW'(FrameData[FB-1:0]), 32'h0BAD_F00F);
    chk("f0_top",    FW'(FrameData[FW-1 -: FB]), 32'h0BAD_F000);
    chk("f0_data",   FrameData, exp_frame);
    @(posedge CLK); #1;

    // Gappy frame 2, then frame 19 right after its strobe cycle
    send_frame(32'hFFFF_0002, 32'h2222_0000, 1'b1, 1'b1);
    chk("f2_strobe", FW'(FrameStrobe), FW'(20'h00004));
    chk("f2_ready",  FW'(WordReady), 0);
    chk("f2_data",   FrameData, exp_frame);
    send_frame(32'h0000_0013, 32'h1919_0000, 1'b1, 1'b1);
    chk("f19_strobe", FW'(FrameStrobe), FW'(20'h80000));
    chk("f19_ready",  FW'(WordReady), 0);
    chk("f19_data",   FrameData, exp_frame);
    chk("f19_err",    FW'(FrameErr), 0);
    @(posedge CLK); #1;
    chk("f19_strobe_off", FW'(FrameStrobe), '0);
    chk("f19_ready_back", FW'(WordReady), 1);
    chk("f19_hold",   FrameData, exp_frame);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
